// File: rtl/tcdm_port_arbiter.sv
// Per-port round-robin arbiter sharing NB_PORTS TCDM master ports among NB_REQ requesters; ID FIFOs route
// in-order responses back to the issuer. Define TCDM_ARB_STALL_CNT_EN for per-port stall counters.
module tcdm_port_arbiter #(
    parameter int NB_REQ          = 2,
    parameter int NB_PORTS        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NB_REQ*NB_PORTS-1:0]                 in_req_i,
    input  logic [NB_REQ*NB_PORTS*ADDR_WIDTH-1:0]      in_add_i,
    input  logic [NB_REQ*NB_PORTS-1:0]                 in_wen_i,
    input  logic [NB_REQ*NB_PORTS*(DATA_WIDTH/8)-1:0]  in_be_i,
    input  logic [NB_REQ*NB_PORTS*DATA_WIDTH-1:0]      in_data_i,
    output logic [NB_REQ*NB_PORTS-1:0]                 in_gnt_o,
    output logic [NB_REQ*NB_PORTS-1:0]                 in_r_valid_o,
    output logic [NB_REQ*NB_PORTS*DATA_WIDTH-1:0]      in_r_data_o,
    output logic [NB_PORTS-1:0]                        tcdm_req_o,
    output logic [NB_PORTS*ADDR_WIDTH-1:0]             tcdm_add_o,
    output logic [NB_PORTS-1:0]                        tcdm_wen_o,
    output logic [NB_PORTS*(DATA_WIDTH/8)-1:0]         tcdm_be_o,
    output logic [NB_PORTS*DATA_WIDTH-1:0]             tcdm_data_o,
    input  logic [NB_PORTS-1:0]                        tcdm_gnt_i,
    input  logic [NB_PORTS-1:0]                        tcdm_r_valid_i,
    input  logic [NB_PORTS*DATA_WIDTH-1:0]             tcdm_r_data_i,
`ifdef TCDM_ARB_STALL_CNT_EN
    input  logic                                       stall_clr_i,
    output logic [NB_PORTS*16-1:0]                     stall_cnt_o,
`endif
    output logic [NB_PORTS-1:0]                        resp_err_o
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int RW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
        logic [RW-1:0]                      rr_ptr_q, rr_ptr_d;
        logic                               lock_q, lock_d;
        logic [RW-1:0]                      lock_idx_q, lock_idx_d;
        logic [MAX_OUTSTANDING-1:0][RW-1:0] fifo_q, fifo_d;
        logic [PW-1:0]                      wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CW-1:0]                      cnt_q, cnt_d;
        logic                               err_q, err_d;
        logic [NB_REQ-1:0]                  req_col, gnt_col;
        logic                               win_vld, req_out, full, push, pop;
        logic [RW-1:0]                      win_idx, head;
        logic [ADDR_WIDTH-1:0]              add_mux;
        logic                               wen_mux;
        logic [BW-1:0]                      be_mux;
        logic [DATA_WIDTH-1:0]              data_mux;

        always_comb begin
            req_col = '0;
            for (int r = 0; r < NB_REQ; r++) req_col[r] = in_req_i[r*NB_PORTS+p];
        end

        // Descending scan: the last hit assigned is the nearest requester at or after rr_ptr.
        always_comb begin : p_win
            logic [RW:0] idx;
            win_vld = 1'b0;
            win_idx = '0;
            idx     = '0;
            if (lock_q) begin
                win_vld = req_col[lock_idx_q];
                win_idx = lock_idx_q;
            end else begin
                for (int i = NB_REQ - 1; i >= 0; i--) begin
                    idx = {1'b0, rr_ptr_q} + (RW+1)'(i);
                    if (idx >= (RW+1)'(NB_REQ)) idx = idx - (RW+1)'(NB_REQ);
                    if (req_col[idx[RW-1:0]]) begin
                        win_vld = 1'b1;
                        win_idx = idx[RW-1:0];
                    end
                end
            end
        end

        assign full    = (cnt_q == CW'(MAX_OUTSTANDING));
        assign req_out = win_vld & ~full;
        assign push    = req_out & tcdm_gnt_i[p];
        assign pop     = tcdm_r_valid_i[p] & (cnt_q != '0);
        assign head    = fifo_q[rptr_q];

        always_comb begin
            add_mux  = '0;
            wen_mux  = 1'b0;
            be_mux   = '0;
            data_mux = '0;
            gnt_col  = '0;
            if (win_vld) begin
                add_mux  = in_add_i[(int'(win_idx)*NB_PORTS+p)*ADDR_WIDTH +: ADDR_WIDTH];
                wen_mux  = in_wen_i[int'(win_idx)*NB_PORTS+p];
                be_mux   = in_be_i[(int'(win_idx)*NB_PORTS+p)*BW +: BW];
                data_mux = in_data_i[(int'(win_idx)*NB_PORTS+p)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (push) gnt_col[win_idx] = 1'b1;
        end

        always_comb begin
            rr_ptr_d   = rr_ptr_q;
            lock_d     = req_out & ~tcdm_gnt_i[p];
            lock_idx_d = lock_idx_q;
            fifo_d     = fifo_q;
            wptr_d     = wptr_q;
            rptr_d     = rptr_q;
            cnt_d      = cnt_q;
            err_d      = err_q | (tcdm_r_valid_i[p] & (cnt_q == '0));
            if (req_out && !tcdm_gnt_i[p]) lock_idx_d = win_idx;
            if (push) begin
                rr_ptr_d       = (win_idx == RW'(NB_REQ - 1)) ? '0 : win_idx + 1'b1;
                fifo_d[wptr_q] = win_idx;
                wptr_d         = wptr_q + 1'b1;
            end
            if (pop) rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_ptr_q   <= '0;
                lock_q     <= 1'b0;
                lock_idx_q <= '0;
                fifo_q     <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                cnt_q      <= '0;
                err_q      <= 1'b0;
            end else begin
                rr_ptr_q   <= rr_ptr_d;
                lock_q     <= lock_d;
                lock_idx_q <= lock_idx_d;
                fifo_q     <= fifo_d;
                wptr_q     <= wptr_d;
                rptr_q     <= rptr_d;
                cnt_q      <= cnt_d;
                err_q      <= err_d;
            end
        end

        assign tcdm_req_o[p]                          = req_out;
        assign tcdm_add_o[p*ADDR_WIDTH +: ADDR_WIDTH] = add_mux;
        assign tcdm_wen_o[p]                          = wen_mux;
        assign tcdm_be_o[p*BW +: BW]                  = be_mux;
        assign tcdm_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data_mux;
        assign resp_err_o[p]                          = err_q;

        for (genvar r = 0; r < NB_REQ; r++) begin : g_req
            assign in_gnt_o[r*NB_PORTS+p]     = gnt_col[r];
            assign in_r_valid_o[r*NB_PORTS+p] = pop & (head == RW'(r));
            assign in_r_data_o[(r*NB_PORTS+p)*DATA_WIDTH +: DATA_WIDTH] =
                tcdm_r_data_i[p*DATA_WIDTH +: DATA_WIDTH];
        end

`ifdef TCDM_ARB_STALL_CNT_EN
        logic [15:0] stall_q, stall_d;

        always_comb begin
            stall_d = stall_q;
            if (stall_clr_i) stall_d = '0;
            else if (|(req_col & ~gnt_col) && stall_q != 16'hFFFF) stall_d = stall_q + 1'b1;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) stall_q <= '0;
            else         stall_q <= stall_d;
        end

        assign stall_cnt_o[p*16 +: 16] = stall_q;
`endif
    end

endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// Scoreboard bench for tcdm_port_arbiter: directed stimulus pushes expected grants/responses, a monitor
// pops and compares whenever the DUT hands something out. A small TCDM slave answers one cycle later.
module tb_tcdm_port_arbiter;
    localparam int NR = 2, NP = 4, AW = 32, DW = 32, BW = DW / 8, MO = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR*NP-1:0]     in_req, in_wen, in_gnt, in_rv;
    logic [NR*NP*AW-1:0]  in_add;
    logic [NR*NP*BW-1:0]  in_be;
    logic [NR*NP*DW-1:0]  in_data, in_rdata;
    logic [NP-1:0]        t_req, t_wen, t_gnt, t_rv, resp_err;
    logic [NP*AW-1:0]     t_add;
    logic [NP*BW-1:0]     t_be;
    logic [NP*DW-1:0]     t_data, t_rdata;
`ifdef TCDM_ARB_STALL_CNT_EN
    logic                 stall_clr;
    logic [NP*16-1:0]     stall_cnt;
`endif

    typedef struct {
        int          req;
        logic [31:0] val;
    } exp_t;

    exp_t        gnt_q[NP][$];
    exp_t        rsp_q[NP][$];
    logic [31:0] pend_q[NP][$];
    logic [NP-1:0] rsp_en, spur;
    logic [NR-1:0] gcol, vcol;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    tcdm_port_arbiter #(.NB_REQ(NR), .NB_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_i(in_req), .in_add_i(in_add), .in_wen_i(in_wen), .in_be_i(in_be), .in_data_i(in_data),
        .in_gnt_o(in_gnt), .in_r_valid_o(in_rv), .in_r_data_o(in_rdata),
        .tcdm_req_o(t_req), .tcdm_add_o(t_add), .tcdm_wen_o(t_wen), .tcdm_be_o(t_be),
        .tcdm_data_o(t_data), .tcdm_gnt_i(t_gnt), .tcdm_r_valid_i(t_rv), .tcdm_r_data_i(t_rdata),
`ifdef TCDM_ARB_STALL_CNT_EN
        .stall_clr_i(stall_clr), .stall_cnt_o(stall_cnt),
`endif
        .resp_err_o(resp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input int p, input logic on, input logic [31:0] addr);
        in_req[r*NP+p]          = on;
        in_wen[r*NP+p]          = 1'b1;
        in_add[(r*NP+p)*AW +: AW] = addr;
        in_be[(r*NP+p)*BW +: BW]  = on ? '1 : '0;
        in_data[(r*NP+p)*DW +: DW] = addr;
    endtask

    task automatic exp_gnt(input int p, input int r, input logic [31:0] addr);
        gnt_q[p].push_back('{r, addr});
    endtask

    task automatic exp_txn(input int p, input int r, input logic [31:0] addr, input logic [31:0] data);
        gnt_q[p].push_back('{r, addr});
        rsp_q[p].push_back('{r, data});
    endtask

    // TCDM slave: answers each handshake one cycle later with data = addr ^ 0xDEAD0000.
    always @(negedge clk) begin
        #1;
        for (int p = 0; p < NP; p++) begin
            t_rv[p] = 1'b0;
            t_rdata[p*DW +: DW] = '0;
            if (rsp_en[p] && pend_q[p].size() > 0) begin
                t_rv[p] = 1'b1;
                t_rdata[p*DW +: DW] = pend_q[p].pop_front();
            end else if (spur[p]) begin
                t_rv[p] = 1'b1;
                t_rdata[p*DW +: DW] = 32'hBAD0_0000;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst_n) begin
            for (int p = 0; p < NP; p++) begin
                for (int r = 0; r < NR; r++) begin
                    gcol[r] = in_gnt[r*NP+p];
                    vcol[r] = in_rv[r*NP+p];
                end
                if (t_req[p] && t_gnt[p]) begin
                    pend_q[p].push_back(t_add[p*AW +: AW] ^ 32'hDEAD_0000);
                    if (gnt_q[p].size() == 0) chk("gnt_unexpected", 64'(gcol), 64'(0));
                    else begin
                        e = gnt_q[p].pop_front();
                        chk("gnt_who", 64'(gcol), 64'(1) << e.req);
                        chk("gnt_addr", 64'(t_add[p*AW +: AW]), 64'(e.val));
                    end
                end else chk("gnt_idle", 64'(gcol), 64'(0));
                if (vcol != '0) begin
                    if (rsp_q[p].size() == 0) chk("rsp_unexpected", 64'(vcol), 64'(0));
                    else begin
                        e = rsp_q[p].pop_front();
                        chk("rsp_who", 64'(vcol), 64'(1) << e.req);
                        chk("rsp_data", 64'(in_rdata[(e.req*NP+p)*DW +: DW]), 64'(e.val));
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_req = '0; in_wen = '0; in_add = '0; in_be = '0; in_data = '0;
        t_gnt = '0; rsp_en = '1; spur = '0;
`ifdef TCDM_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #4;
        chk("rst_tcdm_req", 64'(t_req), 64'(0));
        chk("rst_in_gnt", 64'(in_gnt), 64'(0));
        chk("rst_in_rvalid", 64'(in_rv), 64'(0));
        chk("rst_resp_err", 64'(resp_err), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        // Two requesters on port0, always granted: strict alternation R0,R1,...
        @(negedge clk);
        t_gnt[0] = 1'b1;
        set_req(0, 0, 1'b1, 32'h0000_0100);
        set_req(1, 0, 1'b1, 32'h0000_0200);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) exp_txn(0, 0, 32'h0000_0100, 32'hDEAD_0100);
            else            exp_txn(0, 1, 32'h0000_0200, 32'hDEAD_0200);
        end
        repeat (6) @(negedge clk);
        set_req(0, 0, 1'b0, '0); set_req(1, 0, 1'b0, '0); t_gnt[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Lock: R1 stalled 3 cycles on port2 while R0 joins; R1 keeps the port.
        t_gnt[2] = 1'b0;
        set_req(1, 2, 1'b1, 32'h1000_0040);
        exp_txn(2, 1, 32'h1000_0040, 32'hCEAD_0040);
        exp_txn(2, 0, 32'h2000_0080, 32'hFEAD_0080);
        #4 chk("lock_req_c1", 64'(t_req[2]), 64'(1));
        chk("lock_addr_c1", 64'(t_add[2*AW +: AW]), 64'h1000_0040);
        @(negedge clk) set_req(0, 2, 1'b1, 32'h2000_0080);
        #4 chk("lock_addr_c2", 64'(t_add[2*AW +: AW]), 64'h1000_0040);
        @(negedge clk);
        #4 chk("lock_addr_c3", 64'(t_add[2*AW +: AW]), 64'h1000_0040);
        @(negedge clk) t_gnt[2] = 1'b1;
        #4 chk("lock_gnt_r1", 64'(in_gnt[1*NP+2]), 64'(1));
        @(negedge clk) set_req(1, 2, 1'b0, '0);
        #4 chk("lock_gnt_r0", 64'(in_gnt[0*NP+2]), 64'(1));
        @(negedge clk) set_req(0, 2, 1'b0, '0); t_gnt[2] = 1'b0;
        repeat (3) @(negedge clk);

        // Outstanding limit on port1: 4 handshakes, then masked until a response frees a slot.
        rsp_en[1] = 1'b0; t_gnt[1] = 1'b1;
        set_req(0, 1, 1'b1, 32'h0000_0300);
        for (int k = 0; k < 5; k++) exp_txn(1, 0, 32'h0000_0300, 32'hDEAD_0300);
        repeat (4) @(negedge clk);
        #4 chk("full_mask_a", 64'(t_req[1]), 64'(0));
        @(negedge clk);
        #4 chk("full_mask_b", 64'(t_req[1]), 64'(0));
        @(negedge clk) rsp_en[1] = 1'b1;
        #4 chk("full_mask_on_pop", 64'(t_req[1]), 64'(0));
        @(negedge clk) rsp_en[1] = 1'b0;
        #4 chk("full_resume", 64'(t_req[1]), 64'(1));
        @(negedge clk) set_req(0, 1, 1'b0, '0); t_gnt[1] = 1'b0; rsp_en[1] = 1'b1;
        repeat (6) @(negedge clk);

        // Spurious response on port3.
        spur[3] = 1'b1;
        #4 chk("spur_no_rvalid", 64'(in_rv), 64'(0));
        @(negedge clk) spur[3] = 1'b0;
        #4 chk("spur_err", 64'(resp_err), 64'b1000);
        repeat (3) @(negedge clk);
        #4 chk("spur_err_sticky", 64'(resp_err), 64'b1000);

        // Reset with two port0 requests in flight; rr_ptr[0] is 1 beforehand.
        @(negedge clk) rsp_en[0] = 1'b0; t_gnt[0] = 1'b1;
        set_req(0, 0, 1'b1, 32'h0000_0400);
        exp_gnt(0, 0, 32'h0000_0400); exp_gnt(0, 0, 32'h0000_0400);
        repeat (2) @(negedge clk);
        set_req(0, 0, 1'b0, '0); t_gnt[0] = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #4 chk("rst_err_clear", 64'(resp_err), 64'(0));
        @(negedge clk) rsp_en[0] = 1'b1;
        #4 chk("late_rsp_drop", 64'(in_rv), 64'(0));
        @(negedge clk) rsp_en[0] = 1'b0; pend_q[0].delete();
        #4 chk("late_rsp_err", 64'(resp_err), 64'b0001);
        @(negedge clk) rsp_en[0] = 1'b1; t_gnt[0] = 1'b1;
        set_req(0, 0, 1'b1, 32'h0000_0500);
        set_req(1, 0, 1'b1, 32'h0000_0600);
        exp_txn(0, 0, 32'h0000_0500, 32'hDEAD_0500);
        exp_txn(0, 1, 32'h0000_0600, 32'hDEAD_0600);
        #4 chk("tie_after_rst_r0", 64'(in_gnt[0*NP+0]), 64'(1));
        @(negedge clk) set_req(0, 0, 1'b0, '0);
        @(negedge clk) set_req(1, 0, 1'b0, '0); t_gnt[0] = 1'b0;
        repeat (3) @(negedge clk);

`ifdef TCDM_ARB_STALL_CNT_EN
        stall_clr = 1'b1;
        @(negedge clk) stall_clr = 1'b0;
        set_req(0, 0, 1'b1, 32'h0000_0700);
        #4 chk("stall_cleared", 64'(stall_cnt[15:0]), 64'(0));
        repeat (10) @(negedge clk);
        set_req(0, 0, 1'b0, '0);
        #4 chk("stall_cnt_10", 64'(stall_cnt[15:0]), 64'd10);
        @(negedge clk) stall_clr = 1'b1;
        @(negedge clk) stall_clr = 1'b0;
        #4 chk("stall_clr", 64'(stall_cnt[15:0]), 64'(0));
        repeat (2) @(negedge clk);
`endif

        for (int p = 0; p < NP; p++) begin
            chk("gnt_q_drained", 64'(gnt_q[p].size()), 64'(0));
            chk("rsp_q_drained", 64'(rsp_q[p].size()), 64'(0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
